// File: rtl/arith_pkg.sv
// Shared constants and state encoding for the sequential 64-bit add/subtract unit.
package arith_pkg;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned HALF  = WIDTH / 2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLow  = 2'd1,
        StHigh = 2'd2,
        StDone = 2'd3
    } seq_state_e;

endpackage

// File: rtl/rca_32bits.sv
// 32-bit ripple-carry adder: sum = a + b + cin, with carry-out of bit 31.
module rca_32bits (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    always_comb begin
        logic carry;
        carry = cin;
        sum   = '0;
        for (int i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/rca_seq_ctrl.sv
// Two-pass 64-bit add/subtract built on one shared rca_32bits; low half first,
// high half next, joined by a registered carry. start/ready/busy/done handshake.
module rca_seq_ctrl
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = arith_pkg::WIDTH,
    parameter int unsigned HALF  = arith_pkg::HALF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    seq_state_e state_q, state_d;

    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [HALF-1:0]  add_a;
    logic [HALF-1:0]  add_b;
    logic [HALF-1:0]  add_sum;
    logic             add_co;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StLow;
            StLow:  state_d = StHigh;
            StHigh: state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs
    always_comb begin
        ready = (state_q == StIdle);
        busy  = (state_q != StIdle);
        done  = (state_q == StDone);
    end

    // Shared adder: high-half operands only in StHigh, low half otherwise
    always_comb begin
        if (state_q == StHigh) begin
            add_a = opa_q[WIDTH-1:HALF];
            add_b = opb_q[WIDTH-1:HALF];
        end else begin
            add_a = opa_q[HALF-1:0];
            add_b = opb_q[HALF-1:0];
        end
    end

    rca_32bits u_rca (
        .a    (add_a),
        .b    (add_b),
        .cin  (c_q),
        .sum  (add_sum),
        .cout (add_co)
    );

    // Datapath next-state; subtract is a + ~b + 1, so cin is forced high
    always_comb begin
        opa_d    = opa_q;
        opb_d    = opb_q;
        c_d      = c_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    opa_d = a;
                    opb_d = (op_sub == OP_SUB) ? ~b : b;
                    c_d   = (op_sub == OP_SUB) ? 1'b1 : cin;
                end
            end
            StLow: begin
                result_d[HALF-1:0] = add_sum;
                c_d                = add_co;
            end
            StHigh: begin
                result_d[WIDTH-1:HALF] = add_sum;
                cout_d                 = add_co;
                ovf_d = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                        (add_sum[HALF-1] != opa_q[WIDTH-1]);
            end
            StDone: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa_q    <= '0;
            opb_q    <= '0;
            c_q      <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            c_q      <= c_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl: vector table plus busy-start and reset sequences.
module tb_rca_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op_sub;
    logic        cin;
    logic [63:0] a;
    logic [63:0] b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        cout;
    logic        ovf;

    int checks;
    int errors;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic        op_sub;
        logic        cin;
        logic [63:0] exp_result;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[9];

    rca_seq_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_sub (op_sub),
        .cin    (cin),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one operation from IDLE and watch six cycles after the accept edge.
    task automatic run_vec(input vec_t v);
        int lat;
        lat = 0;
        @(negedge clk);
        chk({v.name, "_ready"}, 64'(ready), 64'd1);
        a      = v.a;
        b      = v.b;
        op_sub = v.op_sub;
        cin    = v.cin;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            if (n > 1) @(negedge clk);
            if (done && lat == 0) begin
                lat = n;
                chk({v.name, "_result"}, result, v.exp_result);
                chk({v.name, "_cout"}, 64'(cout), 64'(v.exp_cout));
                chk({v.name, "_ovf"}, 64'(ovf), 64'(v.exp_ovf));
            end
        end
        chk({v.name, "_latency"}, 64'(lat), 64'd3);
        chk({v.name, "_held"}, result, v.exp_result);
    endtask

    initial begin
        int dones;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        op_sub = 1'b0;
        cin    = 1'b0;
        a      = '0;
        b      = '0;

        vecs[0] = '{"carry_halves", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                    64'h0000_0001_0000_0000, 1'b0, 1'b0};
        vecs[1] = '{"full_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1,
                    64'd0, 1'b1, 1'b0};
        vecs[2] = '{"signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                    64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[3] = '{"sub_borrow", 64'd5, 64'd7, 1'b1, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{"sub_pos", 64'd7, 64'd5, 1'b1, 1'b0, 64'd2, 1'b1, 1'b0};
        vecs[5] = '{"sub_neg_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0,
                    64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[6] = '{"add_neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    1'b0, 1'b0, 64'd0, 1'b1, 1'b1};
        vecs[7] = '{"add_mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
                    1'b0, 1'b0, 64'h2222_2222_2222_2211, 1'b0, 1'b0};
        vecs[8] = '{"sub_zero", 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Starts in LOW and DONE are ignored; the IDLE start after DONE is taken
        dones = 0;
        @(negedge clk);
        a = 64'd1; b = 64'd2; op_sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        chk("busy_low_busy", 64'(busy), 64'd1);
        a = 64'd100; b = 64'd200;
        @(negedge clk);
        dones += int'(done);
        start = 1'b0;
        @(negedge clk);
        dones += int'(done);
        chk("busy_done_pulse", 64'(done), 64'd1);
        chk("busy_result", result, 64'd3);
        start = 1'b1;
        @(negedge clk);
        dones += int'(done);
        chk("busy_idle_ready", 64'(ready), 64'd1);
        chk("busy_idle_result", result, 64'd3);
        @(negedge clk);
        dones += int'(done);
        chk("busy_reaccept", 64'(busy), 64'd1);
        start = 1'b0;
        @(negedge clk);
        dones += int'(done);
        @(negedge clk);
        dones += int'(done);
        chk("busy_second_result", result, 64'd300);
        chk("busy_done_count", 64'(dones), 64'd2);

        // Reset asserted during HIGH abandons the operation
        @(negedge clk);
        a = 64'd10; b = 64'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", 64'(ready), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_result", result, 64'd0);
        dones = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            dones += int'(done);
        end
        chk("midrst_no_done", 64'(dones), 64'd0);

        // rst and start together: rst wins
        rst = 1'b1; start = 1'b1; a = 64'd3; b = 64'd4;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_start_ready", 64'(ready), 64'd1);
        chk("rst_start_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
